// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector with overlap control,
// saturating match counter and checked runtime configuration.
module seq_detector_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_1001),
  parameter int                 RST_LEN     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din,
  input  logic                         din_valid,
  input  logic                         cfg_we,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         cnt_clr,
  output logic                         match,
  output logic [CNT_W-1:0]             match_count,
  output logic                         cfg_err,
  output logic [1:0]                   state
);

  localparam int LW = $clog2(MAX_LEN+1);

  localparam logic [1:0] S_FILL = 2'b01;
  localparam logic [1:0] S_DET  = 2'b10;

  localparam logic [LW-1:0]    FILL_MAX = LW'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LW-1:0]      len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic [1:0]         state_q, state_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] hist_sh;
  logic [LW-1:0]      fill_inc;
  logic               cfg_ok;
  logic               state_ok;
  logic               hit;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= RST_PATTERN;
      len_q     <= LW'(RST_LEN);
      overlap_q <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      state_q   <= S_FILL;
      match_q   <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Only the low len bits of the pattern take part in the compare
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LW'(i) < len_q);
    end
  end

  assign hist_sh  = {hist_q[MAX_LEN-2:0], din};
  assign fill_inc = (fill_q == FILL_MAX) ? fill_q : fill_q + LW'(1);
  assign cfg_ok   = (cfg_len != '0) && (cfg_len <= FILL_MAX);
  assign state_ok = (state_q == S_FILL) || (state_q == S_DET);
  assign hit      = (fill_inc >= len_q) &&
                    (((hist_sh ^ pattern_q) & mask) == '0);

  // Next-state logic
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    state_d   = state_q;
    match_d   = 1'b0;
    err_d     = 1'b0;

    if (cfg_we) begin
      if (cfg_ok) begin
        pattern_d = cfg_pattern;
        len_d     = cfg_len;
        overlap_d = cfg_overlap;
        fill_d    = '0;
        state_d   = S_FILL;
      end else begin
        err_d = 1'b1;
        if (!state_ok) begin
          fill_d  = '0;
          state_d = S_FILL;
        end
      end
    end else if (!state_ok) begin
      fill_d  = '0;
      state_d = S_FILL;
    end else if (din_valid) begin
      hist_d  = hist_sh;
      match_d = hit;
      fill_d  = (hit && !overlap_q) ? '0 : fill_inc;
      state_d = (fill_d >= len_q) ? S_DET : S_FILL;
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Outputs
  always_comb begin
    match       = match_q;
    match_count = cnt_q;
    cfg_err     = err_q;
    state       = state_q;
  end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog: a bit-queue reference
// model predicts each cycle's outputs; a monitor compares them.
module tb_seq_detector_prog;

  localparam int ML   = 8;
  localparam int CW   = 2;
  localparam int LW   = $clog2(ML+1);
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic          cfg_we = 1'b0;
  logic [ML-1:0] cfg_pattern = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          cfg_overlap = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          match;
  logic [CW-1:0] match_count;
  logic          cfg_err;
  logic [1:0]    state;

  seq_detector_prog #(
    .MAX_LEN(ML),
    .CNT_W(CW),
    .RST_PATTERN(8'b0000_1001),
    .RST_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_valid(din_valid),
    .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr),
    .match(match),
    .match_count(match_count),
    .cfg_err(cfg_err),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m;
    int cnt;
    int err;
    int st;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  bit            hq[$];
  int            since = 0;
  logic [ML-1:0] mpat = 8'b0000_1001;
  int            mlen = 4;
  bit            mov = 0;
  int            mcnt = 0;

  function automatic void chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endfunction

  task automatic model(bit r, bit we, logic [ML-1:0] pat, int ln,
                       bit ov, bit dv, bit d, bit clr);
    exp_t e;
    bit   hit = 0;
    e.err = 0;
    if (r) begin
      mpat = 8'b0000_1001;
      mlen = 4;
      mov  = 0;
      hq.delete();
      since = 0;
      mcnt  = 0;
    end else begin
      if (we) begin
        if (ln >= 1 && ln <= ML) begin
          mpat  = pat;
          mlen  = ln;
          mov   = ov;
          since = 0;
        end else begin
          e.err = 1;
        end
      end else if (dv) begin
        hq.push_back(d);
        if (hq.size() > ML) void'(hq.pop_front());
        if (since < ML) since++;
        if (since >= mlen) begin
          hit = 1;
          for (int k = 0; k < mlen; k++)
            if (hq[hq.size()-1-k] != mpat[k]) hit = 0;
        end
        if (hit && !mov) since = 0;
      end
      if (clr) mcnt = 0;
      else if (hit && mcnt < CMAX) mcnt++;
    end
    e.m   = hit;
    e.cnt = mcnt;
    e.st  = (since >= mlen) ? 2 : 1;
    sbq.push_back(e);
  endtask

  task automatic step(bit r, bit we, logic [ML-1:0] pat, int ln,
                      bit ov, bit dv, bit d, bit clr);
    @(negedge clk);
    rst         = r;
    cfg_we      = we;
    cfg_pattern = pat;
    cfg_len     = LW'(ln);
    cfg_overlap = ov;
    din_valid   = dv;
    din         = d;
    cnt_clr     = clr;
    model(r, we, pat, ln, ov, dv, d, clr);
  endtask

  task automatic bitv(bit d);
    step(0, 0, '0, 0, 0, 1, d, 0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset();
    step(1, 0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg(logic [ML-1:0] p, int ln, bit ov);
    step(0, 1, p, ln, ov, 0, 0, 0);
  endtask

  task automatic stream(int n, logic [31:0] bits);
    for (int i = n - 1; i >= 0; i--) bitv(bits[i]);
  endtask

  // Monitor: one expected response per clock after each stimulus
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("match", int'(match), e.m);
        chk("match_count", int'(match_count), e.cnt);
        chk("cfg_err", int'(cfg_err), e.err);
        chk("state", int'(state), e.st);
      end
    end
  end

  initial begin
    int lens[4] = '{2, 3, 4, ML};
    reset();
    idle(1);
    // Default 1001, non-overlap
    stream(7, 32'b1001001);
    idle(2);
    // Overlap 1001
    cfg(8'b1001, 4, 1);
    stream(7, 32'b1001001);
    idle(1);
    // Illegal lengths are rejected
    cfg(8'hFF, 0, 0);
    cfg(8'hFF, ML + 1, 0);
    cfg(8'hFF, 15, 0);
    stream(4, 32'b1001);
    idle(1);
    // Count saturation and clear-vs-match priority
    cfg(8'b11, 2, 1);
    stream(6, 32'b111111);
    step(0, 0, '0, 0, 0, 1, 1, 1);
    bitv(1);
    idle(1);
    // Reset mid-pattern
    reset();
    stream(3, 32'b100);
    reset();
    bitv(1);
    stream(3, 32'b001);
    idle(1);
    // Valid gaps, then a config write on the completing bit
    reset();
    bitv(1); idle(3);
    bitv(0); idle(3);
    bitv(0); idle(3);
    bitv(1); idle(1);
    stream(3, 32'b100);
    step(0, 1, 8'b1001, 4, 0, 1, 1, 0);
    stream(4, 32'b1001);
    // Full-width pattern
    cfg(8'b1011_0110, ML, 1);
    stream(16, 32'b1011_0110_1101_1011);
    idle(1);
    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit r, we, dv, clr, d, ov;
      int ln;
      logic [ML-1:0] p;
      r   = ($urandom_range(0, 99) == 0);
      we  = ($urandom_range(0, 19) == 0);
      dv  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 29) == 0);
      d   = 1'($urandom);
      ov  = 1'($urandom);
      p   = ML'($urandom);
      ln  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15)
                                        : lens[$urandom_range(0, 3)];
      step(r, we, p, ln, ov, dv, d, clr);
    end
    idle(1);
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d responses outstanding, expected 0",
               sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detector_prog.md
SEQ_DETECTOR_PROG -- requirements
Module: seq_detector_prog

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 SHALL have parameter CNT_W, default 8: width of the match counter.
REQ-003 SHALL have parameter RST_PATTERN, default 8'b0000_1001: pattern loaded at reset, MAX_LEN bits wide.
REQ-004 SHALL have parameter RST_LEN, default 4: pattern length loaded at reset.
REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port din, input, 1 bit: serial data bit.
REQ-008 SHALL have port din_valid, input, 1 bit: din is sampled only when din_valid=1.
REQ-009 SHALL have port cfg_we, input, 1 bit: configuration write strobe.
REQ-010 SHALL have port cfg_pattern, input, MAX_LEN bits: new pattern; bit [len-1] is matched first, bit [0] last.
REQ-011 SHALL have port cfg_len, input, $clog2(MAX_LEN+1) bits: new pattern length.
REQ-012 SHALL have port cfg_overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-013 SHALL have port cnt_clr, input, 1 bit: clears match_count.
REQ-014 SHALL have port match, output, 1 bit: single-cycle detection pulse.
REQ-015 SHALL have port match_count, output, CNT_W bits: saturating count of matches.
REQ-016 SHALL have port cfg_err, output, 1 bit: single-cycle pulse on a rejected configuration write.
REQ-017 SHALL have port state, output, 2 bits: current FSM state, for debug.

Function
REQ-018 SHALL keep a history shift register hist[MAX_LEN-1:0] and a fill counter.
  - Each accepted bit: hist <= {hist[MAX_LEN-2:0], din}.
  - Fill counter increments and saturates at MAX_LEN.
REQ-019 SHALL implement FSM states:
  - FILL (2'b01): fill < len.
  - DETECT (2'b10): fill >= len.
  - Encoding 2'b00 is reserved for reset; 2'b11 is illegal and SHALL recover to FILL with fill = 0 on the next edge.
REQ-020 SHALL evaluate a match on a din_valid cycle when the post-shift fill >= len and the post-shift hist[len-1:0] == pattern[len-1:0].
REQ-021 SHALL drive match high in the cycle immediately after the edge that sampled the completing bit (one-cycle latency), for exactly one cycle per match.
REQ-022 SHALL, in overlap mode, leave fill unchanged after a match, so a shared suffix/prefix counts again.
REQ-023 SHALL, in non-overlap mode, set fill to 0 on a match and return the FSM to FILL.
REQ-024 SHALL hold hist, fill, state and match=0 on cycles where din_valid=0.
REQ-025 SHALL increment match_count on each match and saturate at 2^CNT_W-1 without wrapping.
REQ-026 SHALL give cnt_clr priority over a simultaneous match: match_count becomes 0, and the match pulse still occurs.
REQ-027 SHALL accept a cfg_we write only when 1 <= cfg_len <= MAX_LEN; an accepted write loads pattern, len and overlap, clears fill to 0, enters FILL, and suppresses match that cycle.
REQ-028 SHALL ignore an illegal cfg_we write, leave the configuration unchanged, and pulse cfg_err for one cycle.
REQ-029 SHALL give cfg_we priority over a same-cycle din_valid: the din bit is discarded whether the write is accepted or rejected.
REQ-030 SHALL NOT clear match_count on a configuration write.
REQ-031 SHALL mask pattern bits above len-1 out of the comparison.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, set:
  - pattern = RST_PATTERN, len = RST_LEN, overlap = 0;
  - hist = 0, fill = 0, state = FILL;
  - match = 0, match_count = 0, cfg_err = 0.
REQ-033 SHALL give rst priority over cfg_we, din_valid and cnt_clr, including mid-pattern.
REQ-034 SHALL, after reset, detect 1001 non-overlapping with no configuration write required.

Verification
REQ-035 Default config, stream 1,0,0,1,0,0,1 (all valid) -> one match pulse, one cycle after the 4th bit; match_count = 1.
REQ-036 Config pattern 1001, len 4, overlap 1, same stream -> matches after bits 4 and 7; match_count = 2.
REQ-037 cfg_len = 0, then cfg_len = MAX_LEN+1 -> cfg_err pulses twice; detection of 1001 unchanged.
REQ-038 Config pattern 11, len 2, overlap 1, CNT_W = 2, 6 consecutive 1s -> match_count saturates at 3; cnt_clr asserted on a match cycle -> count 0 while the match pulse is still seen.
REQ-039 Stream 1,0,0 then rst, then 1 -> no match; then 0,0,1 -> exactly one match.
REQ-040 Stream 1,0,0 with din_valid gaps of 3 cycles, then 1 -> one match; a cfg_we in the same cycle as the final 1 -> bit dropped, no match, fill = 0.
